// File: rtl/axi_full_mst_burst.sv
// -----------------------------------------------------------------------------
// axi_full_mst_burst
//
// Command-driven AXI4-full initiator. A single read or write burst command is
// turned into one AW/W/B or AR/R transaction (INCR bursts only, one transaction
// outstanding). Write beats stream in from the WR_* port, and read beats stream
// out on the RD_* port. Both streams pass straight through to the memory
// channel. DONE pulses for one cycle at the end of every command, and DONE_RESP
// carries the worst response seen during the burst.
//
// Ports
//   CLK, RSTn            clock, asynchronous active-low reset
//   CMD_*                command request (write flag, byte address, AXI LEN)
//   WR_*                 write beat stream into the block
//   RD_*                 read beat stream out of the block
//   DONE, DONE_RESP      completion pulse and worst response (OKAY/SLVERR/DECERR)
//   MEM_AW*, MEM_W*,
//   MEM_B*, MEM_AR*,
//   MEM_R*               AXI4-full initiator interface
//
// Optional feature (macro AXI_MST_STAT_EN)
//   Adds ERR_CNT (16 bit, saturating count of completions with a non-OKAY
//   response) and BEAT_CNT (32 bit, wrapping count of W/R data handshakes).
// -----------------------------------------------------------------------------
module axi_full_mst_burst #(
  parameter int DW     = 128,
  parameter int AW     = 32,
  parameter int IDW    = 8,
  parameter int TXN_ID = 0
) (
  input  logic              CLK,
  input  logic              RSTn,

  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [AW-1:0]     CMD_ADDR,
  input  logic [7:0]        CMD_LEN,

  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [DW-1:0]     WR_DATA,
  input  logic [DW/8-1:0]   WR_STRB,

  output logic              RD_VALID,
  input  logic              RD_READY,
  output logic [DW-1:0]     RD_DATA,
  output logic              RD_LAST,

  output logic              DONE,
  output logic [1:0]        DONE_RESP,

  output logic [IDW-1:0]    MEM_AWID,
  output logic [AW-1:0]     MEM_AWADDR,
  output logic [7:0]        MEM_AWLEN,
  output logic [2:0]        MEM_AWSIZE,
  output logic [1:0]        MEM_AWBURST,
  output logic              MEM_AWVALID,
  input  logic              MEM_AWREADY,

  output logic [DW-1:0]     MEM_WDATA,
  output logic [DW/8-1:0]   MEM_WSTRB,
  output logic              MEM_WLAST,
  output logic              MEM_WVALID,
  input  logic              MEM_WREADY,

  input  logic [IDW-1:0]    MEM_BID,
  input  logic [1:0]        MEM_BRESP,
  input  logic              MEM_BVALID,
  output logic              MEM_BREADY,

  output logic [IDW-1:0]    MEM_ARID,
  output logic [AW-1:0]     MEM_ARADDR,
  output logic [7:0]        MEM_ARLEN,
  output logic [2:0]        MEM_ARSIZE,
  output logic [1:0]        MEM_ARBURST,
  output logic              MEM_ARVALID,
  input  logic              MEM_ARREADY,

  input  logic [IDW-1:0]    MEM_RID,
  input  logic [DW-1:0]     MEM_RDATA,
  input  logic [1:0]        MEM_RRESP,
  input  logic              MEM_RLAST,
  input  logic              MEM_RVALID,
  output logic              MEM_RREADY
`ifdef AXI_MST_STAT_EN
  ,
  output logic [15:0]       ERR_CNT,
  output logic [31:0]       BEAT_CNT
`endif
);

  localparam int BYTES = DW / 8;
  localparam int SZ    = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AWR,
    S_WDAT,
    S_BRSP,
    S_ARD,
    S_RDAT,
    S_FIN
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   addr_q, addr_nxt;
  logic [7:0]      len_q, len_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic [1:0]      resp, resp_nxt;

  logic [AW-1:0]   aligned_addr;
  logic [31:0]     end_off;
  logic            crosses_4k;

  // Response IDs are not checked and the sub-beat address bits are dropped.
  logic            unused_ok;
  assign unused_ok = ^{MEM_BID, MEM_RID, CMD_ADDR[SZ-1:0]};

  assign aligned_addr = {CMD_ADDR[AW-1:SZ], {SZ{1'b0}}};

  // End offset of the burst within its 4KB page. Exactly 4096 still fits.
  assign end_off    = {20'd0, aligned_addr[11:0]} + ((32'(CMD_LEN) + 32'd1) << SZ);
  assign crosses_4k = end_off > 32'd4096;

  // Fixed address-channel fields and data pass-throughs.
  assign MEM_AWID    = IDW'(TXN_ID);
  assign MEM_ARID    = IDW'(TXN_ID);
  assign MEM_AWSIZE  = 3'(SZ);
  assign MEM_ARSIZE  = 3'(SZ);
  assign MEM_AWBURST = 2'b01;
  assign MEM_ARBURST = 2'b01;
  assign MEM_AWADDR  = addr_q;
  assign MEM_ARADDR  = addr_q;
  assign MEM_AWLEN   = len_q;
  assign MEM_ARLEN   = len_q;
  assign MEM_WDATA   = WR_DATA;
  assign MEM_WSTRB   = WR_STRB;
  assign RD_DATA     = MEM_RDATA;
  assign RD_LAST     = MEM_RLAST;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state  <= S_IDLE;
      addr_q <= '0;
      len_q  <= '0;
      cnt    <= '0;
      resp   <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      len_q  <= len_nxt;
      cnt    <= cnt_nxt;
      resp   <= resp_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_q;
    len_nxt     = len_q;
    cnt_nxt     = cnt;
    resp_nxt    = resp;
    CMD_READY   = 1'b0;
    WR_READY    = 1'b0;
    MEM_WVALID  = 1'b0;
    MEM_WLAST   = 1'b0;
    MEM_AWVALID = 1'b0;
    MEM_ARVALID = 1'b0;
    MEM_BREADY  = 1'b0;
    RD_VALID    = 1'b0;
    MEM_RREADY  = 1'b0;
    DONE        = 1'b0;
    DONE_RESP   = 2'b00;

    case (state)
      S_IDLE: begin
        // Gated by RSTn so CMD_READY is low while reset is held, even though
        // the state register already sits in IDLE.
        CMD_READY = RSTn;
        if (CMD_VALID && RSTn) begin
          addr_nxt = aligned_addr;
          len_nxt  = CMD_LEN;
          if (crosses_4k) begin
            resp_nxt  = 2'b10;
            state_nxt = S_FIN;
          end else if (CMD_WRITE) begin
            state_nxt = S_AWR;
          end else begin
            state_nxt = S_ARD;
          end
        end
      end

      S_AWR: begin
        MEM_AWVALID = 1'b1;
        if (MEM_AWREADY) state_nxt = S_WDAT;
      end

      S_WDAT: begin
        WR_READY   = MEM_WREADY;
        MEM_WVALID = WR_VALID;
        MEM_WLAST  = (cnt == len_q);
        if (WR_VALID && MEM_WREADY) begin
          if (cnt == len_q) begin
            cnt_nxt   = '0;
            state_nxt = S_BRSP;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end

      S_BRSP: begin
        MEM_BREADY = 1'b1;
        if (MEM_BVALID) begin
          resp_nxt  = MEM_BRESP;
          state_nxt = S_FIN;
        end
      end

      S_ARD: begin
        MEM_ARVALID = 1'b1;
        if (MEM_ARREADY) state_nxt = S_RDAT;
      end

      S_RDAT: begin
        RD_VALID   = MEM_RVALID;
        MEM_RREADY = RD_READY;
        if (MEM_RVALID && RD_READY) begin
          // DECERR > SLVERR > OKAY numerically, so max is the worst response.
          if (MEM_RRESP > resp) resp_nxt = MEM_RRESP;
          // Whichever of RLAST or the local count ends first closes the burst.
          if (MEM_RLAST || (cnt == len_q)) begin
            cnt_nxt   = '0;
            state_nxt = S_FIN;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end

      S_FIN: begin
        DONE      = 1'b1;
        DONE_RESP = resp;
        resp_nxt  = 2'b00;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef AXI_MST_STAT_EN
  logic [15:0] err_cnt;
  logic [31:0] beat_cnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      err_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      if (DONE && (DONE_RESP != 2'b00) && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
      if ((MEM_WVALID && MEM_WREADY) || (MEM_RVALID && MEM_RREADY))
        beat_cnt <= beat_cnt + 32'd1;
    end
  end

  assign ERR_CNT  = err_cnt;
  assign BEAT_CNT = beat_cnt;
`endif

endmodule

// File: tb/tb_axi_full_mst_burst.sv
// -----------------------------------------------------------------------------
// tb_axi_full_mst_burst
//
// Directed bench for axi_full_mst_burst (DW=128). A small SRAM-like AXI
// responder with a controllable AWREADY and per-beat RRESP sits on the memory
// side. Stimulus is a linear sequence of commands with hand-computed cycle
// timing and data. The ERR_CNT/BEAT_CNT checks build only with AXI_MST_STAT_EN.
// -----------------------------------------------------------------------------
module tb_axi_full_mst_burst;

  logic          CLK;
  logic          RSTn;
  logic          CMD_VALID, CMD_READY, CMD_WRITE;
  logic [31:0]   CMD_ADDR;
  logic [7:0]    CMD_LEN;
  logic          WR_VALID, WR_READY;
  logic [127:0]  WR_DATA;
  logic [15:0]   WR_STRB;
  logic          RD_VALID, RD_READY, RD_LAST;
  logic [127:0]  RD_DATA;
  logic          DONE;
  logic [1:0]    DONE_RESP;
  logic [7:0]    MEM_AWID, MEM_ARID, MEM_BID, MEM_RID;
  logic [31:0]   MEM_AWADDR, MEM_ARADDR;
  logic [7:0]    MEM_AWLEN, MEM_ARLEN;
  logic [2:0]    MEM_AWSIZE, MEM_ARSIZE;
  logic [1:0]    MEM_AWBURST, MEM_ARBURST;
  logic          MEM_AWVALID, MEM_AWREADY, MEM_ARVALID, MEM_ARREADY;
  logic [127:0]  MEM_WDATA, MEM_RDATA;
  logic [15:0]   MEM_WSTRB;
  logic          MEM_WLAST, MEM_WVALID, MEM_WREADY;
  logic [1:0]    MEM_BRESP, MEM_RRESP;
  logic          MEM_BVALID, MEM_BREADY;
  logic          MEM_RLAST, MEM_RVALID, MEM_RREADY;
`ifdef AXI_MST_STAT_EN
  logic [15:0]   ERR_CNT;
  logic [31:0]   BEAT_CNT;
`endif

  int            n_checks;
  int            n_fail;
  logic [127:0]  wpat [4];

  // Responder state and controls.
  logic          aw_rdy_en;
  logic [1:0]    rresp_seq [4];
  logic [127:0]  mem [512];
  logic [8:0]    wptr, rptr;
  logic [7:0]    rlen, rbeat;
  logic          bvalid, rvalid;

  axi_full_mst_burst dut (
    .CLK(CLK), .RSTn(RSTn),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_DATA(WR_DATA), .WR_STRB(WR_STRB),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA), .RD_LAST(RD_LAST),
    .DONE(DONE), .DONE_RESP(DONE_RESP),
    .MEM_AWID(MEM_AWID), .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN),
    .MEM_AWSIZE(MEM_AWSIZE), .MEM_AWBURST(MEM_AWBURST), .MEM_AWVALID(MEM_AWVALID),
    .MEM_AWREADY(MEM_AWREADY),
    .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_WLAST(MEM_WLAST),
    .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
    .MEM_BID(MEM_BID), .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID),
    .MEM_BREADY(MEM_BREADY),
    .MEM_ARID(MEM_ARID), .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN),
    .MEM_ARSIZE(MEM_ARSIZE), .MEM_ARBURST(MEM_ARBURST), .MEM_ARVALID(MEM_ARVALID),
    .MEM_ARREADY(MEM_ARREADY),
    .MEM_RID(MEM_RID), .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP),
    .MEM_RLAST(MEM_RLAST), .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY)
`ifdef AXI_MST_STAT_EN
    ,
    .ERR_CNT(ERR_CNT), .BEAT_CNT(BEAT_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Responder: W and AR are always ready; AW readiness is controlled by
  // aw_rdy_en. B follows the WLAST handshake by one cycle, and R starts one
  // cycle after AR.
  assign MEM_AWREADY = aw_rdy_en;
  assign MEM_WREADY  = 1'b1;
  assign MEM_ARREADY = 1'b1;
  assign MEM_BID     = 8'd0;
  assign MEM_RID     = 8'd0;
  assign MEM_BRESP   = 2'b00;
  assign MEM_BVALID  = bvalid;
  assign MEM_RVALID  = rvalid;
  assign MEM_RDATA   = mem[rptr];
  assign MEM_RRESP   = rresp_seq[rbeat[1:0]];
  assign MEM_RLAST   = (rbeat == rlen);

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wptr   <= '0;
      rptr   <= '0;
      rlen   <= '0;
      rbeat  <= '0;
      bvalid <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      if (MEM_AWVALID && MEM_AWREADY) wptr <= MEM_AWADDR[12:4];
      if (MEM_WVALID && MEM_WREADY) begin
        wptr <= wptr + 9'd1;
        if (MEM_WLAST) bvalid <= 1'b1;
      end
      if (bvalid && MEM_BREADY) bvalid <= 1'b0;
      if (MEM_ARVALID && MEM_ARREADY) begin
        rptr   <= MEM_ARADDR[12:4];
        rlen   <= MEM_ARLEN;
        rbeat  <= '0;
        rvalid <= 1'b1;
      end else if (rvalid && MEM_RREADY) begin
        if (rbeat == rlen) begin
          rvalid <= 1'b0;
        end else begin
          rbeat <= rbeat + 8'd1;
          rptr  <= rptr + 9'd1;
        end
      end
    end
  end

  always @(posedge CLK) begin
    if (MEM_WVALID && MEM_WREADY) begin
      for (int b = 0; b < 16; b++)
        if (MEM_WSTRB[b]) mem[wptr][b*8 +: 8] <= MEM_WDATA[b*8 +: 8];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] obs,
                              input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a command in an IDLE cycle and returns settled in cycle T+1.
  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    CMD_VALID = 1'b1;
    CMD_WRITE = wr;
    CMD_ADDR  = addr;
    CMD_LEN   = len;
    #1;
    check_output("cmd_ready idle", CMD_READY, 1'b1);
    tick();
    CMD_VALID = 1'b0;
    #1;
  endtask

  initial begin
    int k;
    int cyc;
    n_checks  = 0;
    n_fail    = 0;
    RSTn      = 1'b0;
    CMD_VALID = 1'b0;
    CMD_WRITE = 1'b0;
    CMD_ADDR  = '0;
    CMD_LEN   = '0;
    WR_VALID  = 1'b0;
    WR_DATA   = '0;
    WR_STRB   = '1;
    RD_READY  = 1'b0;
    aw_rdy_en = 1'b1;
    for (int i = 0; i < 4; i++) rresp_seq[i] = 2'b00;
    wpat[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    wpat[1] = 128'h01010101_02020202_03030303_04040404;
    wpat[2] = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    wpat[3] = 128'hFFFFFFFF_00000000_A5A5A5A5_5A5A5A5A;

    // Reset values.
    #12;
    check_output("rst cmd_ready", CMD_READY, 1'b0);
    check_output("rst awvalid", MEM_AWVALID, 1'b0);
    check_output("rst arvalid", MEM_ARVALID, 1'b0);
    check_output("rst wvalid", MEM_WVALID, 1'b0);
    check_output("rst wr_ready", WR_READY, 1'b0);
    check_output("rst rd_valid", RD_VALID, 1'b0);
    check_output("rst bready", MEM_BREADY, 1'b0);
    check_output("rst rready", MEM_RREADY, 1'b0);
    check_output("rst done", DONE, 1'b0);
    check_output("rst done_resp", DONE_RESP, 2'b00);
    @(negedge CLK);
    RSTn = 1'b1;
    tick();
    check_output("post-rst cmd_ready", CMD_READY, 1'b1);
`ifdef AXI_MST_STAT_EN
    check_output("rst err_cnt", ERR_CNT, 16'd0);
    check_output("rst beat_cnt", BEAT_CNT, 32'd0);
`endif

    // Write 0x1000, len 3, responder always ready: DONE at T+7.
    WR_VALID = 1'b1;
    WR_DATA  = wpat[0];
    issue_cmd(1'b1, 32'h1000, 8'd3);
    check_output("w1 awvalid", MEM_AWVALID, 1'b1);
    check_output("w1 awaddr", MEM_AWADDR, 32'h1000);
    check_output("w1 awlen", MEM_AWLEN, 8'd3);
    check_output("w1 awsize", MEM_AWSIZE, 3'd4);
    check_output("w1 awburst", MEM_AWBURST, 2'b01);
    check_output("w1 awid", MEM_AWID, 8'd0);
    check_output("w1 no early w", MEM_WVALID, 1'b0);
    check_output("w1 no early wr_ready", WR_READY, 1'b0);
    check_output("w1 cmd_ready busy", CMD_READY, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      WR_DATA = wpat[i];
      #1;
      check_output($sformatf("w1 wvalid b%0d", i), MEM_WVALID, 1'b1);
      check_output($sformatf("w1 wr_ready b%0d", i), WR_READY, 1'b1);
      check_output($sformatf("w1 wdata b%0d", i), MEM_WDATA, wpat[i]);
      check_output($sformatf("w1 wlast b%0d", i), MEM_WLAST, (i == 3) ? 1'b1 : 1'b0);
      tick();
    end
    WR_VALID = 1'b0;
    #1;
    check_output("w1 bready", MEM_BREADY, 1'b1);
    check_output("w1 done early", DONE, 1'b0);
    tick();
    check_output("w1 done T+7", DONE, 1'b1);
    check_output("w1 done_resp", DONE_RESP, 2'b00);
    tick();
    check_output("w1 done pulse", DONE, 1'b0);

    // Read back 0x1000, len 3, RD_READY toggling.
    issue_cmd(1'b0, 32'h1000, 8'd3);
    check_output("r2 arvalid", MEM_ARVALID, 1'b1);
    check_output("r2 araddr", MEM_ARADDR, 32'h1000);
    check_output("r2 arlen", MEM_ARLEN, 8'd3);
    check_output("r2 arsize", MEM_ARSIZE, 3'd4);
    check_output("r2 arburst", MEM_ARBURST, 2'b01);
    check_output("r2 awvalid", MEM_AWVALID, 1'b0);
    tick();
    k   = 0;
    cyc = 0;
    while (DONE !== 1'b1 && cyc < 24) begin
      RD_READY = (cyc % 2 == 1);
      #1;
      if (RD_VALID && RD_READY) begin
        check_output($sformatf("r2 rdata b%0d", k), RD_DATA, (k < 4) ? wpat[k] : 128'd0);
        check_output($sformatf("r2 rlast b%0d", k), RD_LAST, (k == 3) ? 1'b1 : 1'b0);
        k++;
      end
      tick();
      cyc++;
    end
    RD_READY = 1'b0;
    check_output("r2 done", DONE, 1'b1);
    check_output("r2 done_resp", DONE_RESP, 2'b00);
    check_output("r2 beat count", k, 4);
    tick();

    // Read len 1 with RRESP 0 then 3.
`ifdef AXI_MST_STAT_EN
    check_output("r4 err_cnt before", ERR_CNT, 16'd0);
    check_output("r4 beat_cnt before", BEAT_CNT, 32'd8);
`endif
    rresp_seq[1] = 2'b11;
    RD_READY     = 1'b1;
    issue_cmd(1'b0, 32'h1000, 8'd1);
    check_output("r4 arlen", MEM_ARLEN, 8'd1);
    tick();
    check_output("r4 rd_valid b0", RD_VALID, 1'b1);
    check_output("r4 rready b0", MEM_RREADY, 1'b1);
    check_output("r4 rdata b0", RD_DATA, wpat[0]);
    check_output("r4 rlast b0", RD_LAST, 1'b0);
    tick();
    check_output("r4 rdata b1", RD_DATA, wpat[1]);
    check_output("r4 rlast b1", RD_LAST, 1'b1);
    check_output("r4 done early", DONE, 1'b0);
    tick();
    check_output("r4 done", DONE, 1'b1);
    check_output("r4 done_resp", DONE_RESP, 2'b11);
    tick();
    check_output("r4 done pulse", DONE, 1'b0);
`ifdef AXI_MST_STAT_EN
    check_output("r4 err_cnt after", ERR_CNT, 16'd1);
    check_output("r4 beat_cnt after", BEAT_CNT, 32'd10);
`endif
    rresp_seq[1] = 2'b00;
    RD_READY     = 1'b0;

    // Write 0x1FC0, len 7 crosses 4KB: no AXI traffic, SLVERR after 1 cycle.
    WR_VALID = 1'b1;
    WR_DATA  = wpat[3];
    issue_cmd(1'b1, 32'h1FC0, 8'd7);
    check_output("x3 done", DONE, 1'b1);
    check_output("x3 done_resp", DONE_RESP, 2'b10);
    check_output("x3 awvalid", MEM_AWVALID, 1'b0);
    check_output("x3 wr_ready", WR_READY, 1'b0);
    check_output("x3 wvalid", MEM_WVALID, 1'b0);
    tick();
    check_output("x3 done pulse", DONE, 1'b0);
    check_output("x3 wr_ready idle", WR_READY, 1'b0);
    check_output("x3 cmd_ready", CMD_READY, 1'b1);
    WR_VALID = 1'b0;

    // Unaligned read ending exactly at the page end is legal.
    RD_READY = 1'b1;
    issue_cmd(1'b0, 32'h1FF7, 8'd0);
    check_output("b4k arvalid", MEM_ARVALID, 1'b1);
    check_output("b4k araddr aligned", MEM_ARADDR, 32'h1FF0);
    check_output("b4k arlen", MEM_ARLEN, 8'd0);
    tick();
    check_output("b4k rd_valid", RD_VALID, 1'b1);
    check_output("b4k rd_last", RD_LAST, 1'b1);
    tick();
    check_output("b4k done T+3", DONE, 1'b1);
    check_output("b4k done_resp", DONE_RESP, 2'b00);
    tick();
    RD_READY = 1'b0;

    // AWREADY held low for 20 cycles.
    aw_rdy_en = 1'b0;
    WR_VALID  = 1'b1;
    WR_DATA   = wpat[2];
    issue_cmd(1'b1, 32'h1040, 8'd0);
    for (int i = 0; i < 20; i++) begin
      check_output($sformatf("aw5 awvalid c%0d", i), MEM_AWVALID, 1'b1);
      check_output($sformatf("aw5 awaddr c%0d", i), MEM_AWADDR, 32'h1040);
      check_output($sformatf("aw5 no w c%0d", i), MEM_WVALID, 1'b0);
      tick();
    end
    aw_rdy_en = 1'b1;
    #1;
    check_output("aw5 awvalid release", MEM_AWVALID, 1'b1);
    tick();
    check_output("aw5 wvalid", MEM_WVALID, 1'b1);
    check_output("aw5 wlast", MEM_WLAST, 1'b1);
    check_output("aw5 wdata", MEM_WDATA, wpat[2]);
    tick();
    WR_VALID = 1'b0;
    tick();
    check_output("aw5 done", DONE, 1'b1);
    check_output("aw5 done_resp", DONE_RESP, 2'b00);
    tick();

    // Reset during the 3rd W beat of a len-7 write.
    WR_VALID = 1'b1;
    WR_DATA  = wpat[1];
    issue_cmd(1'b1, 32'h2000, 8'd7);
    tick();
    tick();
    tick();
    check_output("rs6 wvalid b2", MEM_WVALID, 1'b1);
    RSTn = 1'b0;
    #1;
    check_output("rs6 wvalid", MEM_WVALID, 1'b0);
    check_output("rs6 wr_ready", WR_READY, 1'b0);
    check_output("rs6 awvalid", MEM_AWVALID, 1'b0);
    check_output("rs6 arvalid", MEM_ARVALID, 1'b0);
    check_output("rs6 bready", MEM_BREADY, 1'b0);
    check_output("rs6 rd_valid", RD_VALID, 1'b0);
    check_output("rs6 done", DONE, 1'b0);
    check_output("rs6 cmd_ready", CMD_READY, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RSTn     = 1'b1;
    WR_VALID = 1'b0;
    tick();
    check_output("rs6 cmd_ready after", CMD_READY, 1'b1);
    RD_READY = 1'b1;
    issue_cmd(1'b0, 32'h1000, 8'd0);
    check_output("rs6 arvalid", MEM_ARVALID, 1'b1);
    tick();
    check_output("rs6 rdata", RD_DATA, wpat[0]);
    check_output("rs6 rlast", RD_LAST, 1'b1);
    tick();
    check_output("rs6 read done", DONE, 1'b1);
    check_output("rs6 read done_resp", DONE_RESP, 2'b00);
    tick();
    RD_READY = 1'b0;
    check_output("rs6 done pulse", DONE, 1'b0);
`ifdef AXI_MST_STAT_EN
    check_output("rs6 err_cnt", ERR_CNT, 16'd0);
    check_output("rs6 beat_cnt", BEAT_CNT, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
